// File: rtl/moore_seq_lock.sv
`default_nettype none
// ============================================================================
// Module      : moore_seq_lock
// Description : Moore-style push-button combination lock. Edge-detected button
//               presses are matched against CODE. Wrong presses are counted
//               and trigger a timed lockout. A correct sequence raises z for a
//               fixed number of cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module moore_seq_lock #(
    parameter int                        NUM_BTN     = 2,
    parameter int                        SEQ_LEN     = 4,
    parameter int                        IDXW        = 1,
    parameter logic [SEQ_LEN*IDXW-1:0]   CODE        = 4'b1100,
    parameter int                        MAX_FAIL    = 3,
    parameter int                        OPEN_CYCLES = 4,
    parameter int                        LOCK_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_BTN-1:0]              P,
    output logic                            z,
    output logic                            locked,
    output logic [$clog2(SEQ_LEN+1)-1:0]    progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int PW   = $clog2(SEQ_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [PW-1:0] LAST_STEP = PW'(SEQ_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

    typedef enum logic [1:0] {
        ST_TRACK   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [PW-1:0]        progress_q, progress_d;
    logic [FW-1:0]        fail_q,     fail_d;
    logic [TW-1:0]        timer_q,    timer_d;
    logic [NUM_BTN-1:0]   p_prev_q,   p_prev_d;

    logic                 w_press;
    logic                 w_valid;
    logic [IDXW-1:0]      w_btn_idx;
    logic [IDXW-1:0]      w_step_idx;
    logic [IDXW-1:0]      w_first_idx;

    // A press is the first non-zero sample after an all-zero sample.
    assign w_press     = (p_prev_q == '0) && (P != '0);
    assign w_valid     = $onehot(P);
    assign w_first_idx = CODE[IDXW-1:0];

    always_comb begin
        w_btn_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (P[i]) w_btn_idx = IDXW'(i);
        end
        w_step_idx = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (progress_q == PW'(k)) w_step_idx = CODE[k*IDXW +: IDXW];
        end
    end

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        p_prev_d   = P;
        unique case (state_q)
            ST_TRACK: begin
                if (w_press) begin
                    if (w_valid && (w_btn_idx == w_step_idx)) begin
                        if (progress_q == LAST_STEP) begin
                            state_d    = ST_OPEN;
                            progress_d = '0;
                            fail_d     = '0;
                            timer_d    = OPEN_LOAD;
                        end else begin
                            progress_d = progress_q + PW'(1);
                        end
                    end else if (fail_q == FAIL_LAST) begin
                        state_d    = ST_LOCKOUT;
                        progress_d = '0;
                        fail_d     = FAIL_MAX;
                        timer_d    = LOCK_LOAD;
                    end else begin
                        fail_d     = fail_q + FW'(1);
                        // A wrong press of the first code button restarts the code.
                        progress_d = (w_valid && (w_btn_idx == w_first_idx)) ? PW'(1) : '0;
                    end
                end
            end
            ST_OPEN: begin
                if (timer_q == '0) begin
                    state_d    = ST_TRACK;
                    progress_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_TRACK;
                    progress_d = '0;
                    fail_d     = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d    = ST_TRACK;
                progress_d = '0;
                fail_d     = '0;
                timer_d    = '0;
            end
        endcase
    end

    // All-ones on reset so a button held through reset release is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_TRACK;
            progress_q <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            p_prev_q   <= '1;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            p_prev_q   <= p_prev_d;
        end
    end

    assign z        = (state_q == ST_OPEN);
    assign locked   = (state_q == ST_LOCKOUT);
    assign progress = progress_q;
    assign fail_cnt = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_seq_lock
// Description : Directed scoreboard bench for moore_seq_lock (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_seq_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] P;
    logic       z;
    logic       locked;
    logic [2:0] progress;
    logic [1:0] fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic  z;
        logic  locked;
        int    prog;
        int    fail;   // -1 = not checked
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    moore_seq_lock dut (
        .clk      (clk),
        .reset    (reset),
        .P        (P),
        .z        (z),
        .locked   (locked),
        .progress (progress),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, ".z"},        int'(z),        int'(mon_e.z));
            check({mon_e.tag, ".locked"},   int'(locked),   int'(mon_e.locked));
            check({mon_e.tag, ".progress"}, int'(progress), mon_e.prog);
            if (mon_e.fail >= 0)
                check({mon_e.tag, ".fail_cnt"}, int'(fail_cnt), mon_e.fail);
        end
    end

    task automatic step(input logic [1:0] p, input logic ez, input logic el,
                        input int ep, input int ef, input string tag);
        exp_t e;
        @(negedge clk);
        P = p;
        e.z = ez; e.locked = el; e.prog = ep; e.fail = ef; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".z"},        int'(z),        0);
        check({tag, ".locked"},   int'(locked),   0);
        check({tag, ".progress"}, int'(progress), 0);
        check({tag, ".fail_cnt"}, int'(fail_cnt), 0);
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge.
    task automatic rst_pulse(input logic [1:0] p, input string tag);
        @(negedge clk);
        reset = 1'b1;
        P     = p;
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic enter_open(input string tag);
        step(2'b01, 0, 0, 1, 0, {tag, "_s1"});
        step(2'b00, 0, 0, 1, 0, {tag, "_g1"});
        step(2'b01, 0, 0, 2, 0, {tag, "_s2"});
        step(2'b00, 0, 0, 2, 0, {tag, "_g2"});
        step(2'b10, 0, 0, 3, 0, {tag, "_s3"});
        step(2'b00, 0, 0, 3, 0, {tag, "_g3"});
        step(2'b10, 1, 0, 0, 0, {tag, "_open1"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, 0 expected");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        P     = 2'b00;
        @(negedge clk);
        check_reset_vals("reset0");
        reset = 1'b0;

        // Correct code opens for exactly four cycles; presses in OPEN ignored
        enter_open("unlock");
        step(2'b01, 1, 0, 0, 0, "unlock_open2");
        step(2'b00, 1, 0, 0, 0, "unlock_open3");
        step(2'b00, 1, 0, 0, 0, "unlock_open4");
        step(2'b00, 0, 0, 0, 0, "unlock_closed");

        // Held button gives one press only
        rst_pulse(2'b00, "rst_hold");
        step(2'b01, 0, 0, 1, 0, "hold_c1");
        for (int i = 0; i < 4; i++) step(2'b01, 0, 0, 1, 0, "hold_cn");
        step(2'b00, 0, 0, 1, 0, "hold_rel");
        step(2'b10, 0, 0, 0, 1, "hold_wrong");
        step(2'b00, 0, 0, 0, 1, "hold_idle");

        // Wrong press with step-0 button restarts at progress 1
        rst_pulse(2'b00, "rst_restart");
        step(2'b01, 0, 0, 1, 0, "rs_p1");
        step(2'b00, 0, 0, 1, 0, "rs_g1");
        step(2'b01, 0, 0, 2, 0, "rs_p2");
        step(2'b00, 0, 0, 2, 0, "rs_g2");
        step(2'b01, 0, 0, 1, 1, "rs_wrong");
        step(2'b00, 0, 0, 1, 1, "rs_idle");

        // Lockout after three wrong presses, code ignored while locked
        rst_pulse(2'b00, "rst_lock");
        step(2'b10, 0, 0, 0, 1, "lk_w1");
        step(2'b00, 0, 0, 0, 1, "lk_g1");
        step(2'b10, 0, 0, 0, 2, "lk_w2");
        step(2'b00, 0, 0, 0, 2, "lk_g2");
        step(2'b10, 0, 1, 0, -1, "lk_enter");
        step(2'b01, 0, 1, 0, -1, "lk_ign1");
        step(2'b00, 0, 1, 0, -1, "lk_ign2");
        step(2'b01, 0, 1, 0, -1, "lk_ign3");
        step(2'b00, 0, 1, 0, -1, "lk_ign4");
        step(2'b10, 0, 1, 0, -1, "lk_ign5");
        step(2'b00, 0, 1, 0, -1, "lk_ign6");
        step(2'b10, 0, 1, 0, -1, "lk_ign7");
        step(2'b00, 0, 1, 0, -1, "lk_ign8");
        for (int i = 0; i < 7; i++) step(2'b00, 0, 1, 0, -1, "lk_wait");
        step(2'b00, 0, 0, 0, 0, "lk_exit");
        step(2'b01, 0, 0, 1, 0, "lk_after_p1");
        step(2'b00, 0, 0, 1, 0, "lk_after_g1");

        // Multi-bit press is wrong; button held through reset is not a press
        rst_pulse(2'b00, "rst_multi");
        step(2'b11, 0, 0, 0, 1, "multi_press");
        step(2'b00, 0, 0, 0, 1, "multi_idle");
        rst_pulse(2'b01, "rst_held");
        step(2'b01, 0, 0, 0, 0, "held_a");
        step(2'b01, 0, 0, 0, 0, "held_b");
        step(2'b00, 0, 0, 0, 0, "held_rel");
        step(2'b01, 0, 0, 1, 0, "held_newpress");
        step(2'b00, 0, 0, 1, 0, "held_idle");

        // Reset during second OPEN cycle aborts; next code unlocks again
        rst_pulse(2'b00, "rst_pre_open");
        enter_open("abort");
        step(2'b00, 1, 0, 0, 0, "abort_open2");
        rst_pulse(2'b00, "rst_mid_open");
        step(2'b00, 0, 0, 0, 0, "abort_after");
        enter_open("reopen");
        step(2'b00, 1, 0, 0, 0, "reopen_open2");
        step(2'b00, 1, 0, 0, 0, "reopen_open3");
        step(2'b00, 1, 0, 0, 0, "reopen_open4");
        step(2'b00, 0, 0, 0, 0, "reopen_closed");

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
